// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the decode/execute pair.
// Tracks register-write metadata for EX/MEM/WB in a shadow pipe, drives the
// operand forwarding selects, resolves load-use stalls, redirect flushes,
// memory-busy freezes and the illegal-instruction drain/trap sequence.
// Optional feature macro: HAZARD_PERF_CNT_EN (enables stall/flush counters;
// when undefined the counters are absent and both count outputs read 0).
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DRAIN_MAX  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_illegal,
    input  logic                  ex_pc_src,
    input  logic                  mem_busy,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_bubble,
    output logic [1:0]            forward_rs1,
    output logic [1:0]            forward_rs2,
    output logic                  trap_req,
    output logic [1:0]            ctrl_state,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
);

    localparam int unsigned DRAIN_CNT_W = (DRAIN_MAX < 1) ? 1 : $clog2(DRAIN_MAX + 1);

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_MEM  = 2'd1;
    localparam logic [1:0] FWD_WB   = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  use_rs1;
        logic                  use_rs2;
    } shadow_t;

    state_t                 state_q, state_d;
    shadow_t                ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    shadow_t                id_entry;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic                   redirect;
    logic                   load_use;
    logic                   illegal_in;
    logic                   pipe_empty;

    // Select the youngest producer of src still in flight; MEM wins over WB.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                           input logic                  use_src,
                                           input shadow_t               m,
                                           input shadow_t               w);
        logic m_hit;
        logic w_hit;
        m_hit = m.valid & m.reg_write & (m.rd != '0) & (m.rd == src) & use_src;
        w_hit = w.valid & w.reg_write & (w.rd != '0) & (w.rd == src) & use_src;
        if (m_hit) begin
            fwd_sel = FWD_MEM;
        end else if (w_hit) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_NONE;
        end
    endfunction

    // Hazard conditions seen this cycle.
    always_comb begin
        id_entry   = id_valid ? {1'b1, id_rd, id_reg_write, id_mem_read,
                                 id_rs1, id_rs2, id_use_rs1, id_use_rs2} : '0;
        redirect   = ex_pc_src & ex_q.valid;
        load_use   = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                     ((id_use_rs1 & (id_rs1 == ex_q.rd)) |
                      (id_use_rs2 & (id_rs2 == ex_q.rd)));
        illegal_in = id_valid & id_illegal;
        pipe_empty = ~ex_q.valid & ~mem_q.valid & ~wb_q.valid;
    end

    // Pipeline control, FSM next state and shadow advance.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        trap_req     = 1'b0;
        state_d      = state_q;
        ex_d         = ex_q;
        mem_d        = mem_q;
        wb_d         = wb_q;
        drain_cnt_d  = drain_cnt_q;

        forward_rs1 = fwd_sel(ex_q.rs1, ex_q.use_rs1, mem_q, wb_q);
        forward_rs2 = fwd_sel(ex_q.rs2, ex_q.use_rs2, mem_q, wb_q);

        if (mem_busy) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (redirect) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else begin
                        // The illegal instruction is held in ID and never enters EX.
                        if (load_use | illegal_in) begin
                            pc_stall     = 1'b1;
                            if_id_stall  = 1'b1;
                            id_ex_bubble = 1'b1;
                        end
                        if (illegal_in) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (redirect) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        state_d      = ST_RUN;
                    end else begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                        // Drain bound is a safety net; the pipe empties first.
                        if (pipe_empty || (drain_cnt_q >= DRAIN_CNT_W'(DRAIN_MAX))) begin
                            state_d = ST_TRAP;
                        end
                    end
                end
                ST_TRAP: begin
                    trap_req     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    state_d      = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase

            drain_cnt_d = ((state_q == ST_DRAIN) && (state_d == ST_DRAIN)) ?
                          drain_cnt_q + DRAIN_CNT_W'(1) : '0;
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = id_ex_bubble ? '0 : id_entry;
        end

        // Reset cycle presents a quiet interface.
        if (reset) begin
            pc_stall     = 1'b0;
            if_id_stall  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_stall  = 1'b0;
            id_ex_bubble = 1'b0;
            trap_req     = 1'b0;
            forward_rs1  = FWD_NONE;
            forward_rs2  = FWD_NONE;
        end
    end

    // State and shadow pipe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign ctrl_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Busy cycles and acted-on load-use stalls; acted-on redirect flushes.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (mem_busy || ((state_q == ST_RUN) && !redirect && load_use)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (!mem_busy && redirect && (state_q != ST_TRAP)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
